// File: rtl/alpha_seq_pkg.sv
// Shared types and constants for the ALPHA startup sequencer.
// Default order: seq3, seq2, i2c, then seq1 gated by button.
package alpha_seq_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DELAY     = 3'd1;
  localparam logic [2:0] S_WAIT_GATE = 3'd2;
  localparam logic [2:0] S_FIRE      = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_DELAY     = S_DELAY,
    ST_WAIT_GATE = S_WAIT_GATE,
    ST_FIRE      = S_FIRE,
    ST_DONE      = S_DONE
  } seq_state_t;

  localparam int DEF_NUM_STAGES      = 4;
  localparam int DEF_DELAY_WIDTH     = 27;
  localparam int DEF_WATCHDOG_CYCLES = 100_000_000;

  localparam logic [3:0] DEF_GATED_MASK = 4'b1000;

  localparam logic [26:0] DLY_SEQ3 = 27'd50_000_000;
  localparam logic [26:0] DLY_SEQ2 = 27'd25_000_000;
  localparam logic [26:0] DLY_I2C  = 27'd10_000_000;
  localparam logic [26:0] DLY_SEQ1 = 27'd1_000;

  localparam logic [4*27-1:0] DEF_STAGE_DELAY =
    {DLY_SEQ1, DLY_I2C, DLY_SEQ2, DLY_SEQ3};

  // Stage index width; a single stage still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alpha_startup_sequencer_if.sv
// Control/status bundle of the startup sequencer.
// master drives commands, slave is the sequencer.
interface alpha_startup_sequencer_if
  import alpha_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH
);
  localparam int IW = idx_width(NUM_STAGES);

  logic                              start;
  logic                              abort;
  logic                              gate;
  logic [NUM_STAGES*DELAY_WIDTH-1:0] stage_delay;
  logic [NUM_STAGES-1:0]             stage_pulse;
  logic [NUM_STAGES-1:0]             stage_done;
  logic [IW-1:0]                     current_stage;
  logic                              busy;
  logic                              all_done;
  logic                              waiting_gate;
  logic                              timeout;

  modport master (
    output start, abort, gate, stage_delay,
    input  stage_pulse, stage_done, current_stage,
    input  busy, all_done, waiting_gate, timeout
  );

  modport slave (
    input  start, abort, gate, stage_delay,
    output stage_pulse, stage_done, current_stage,
    output busy, all_done, waiting_gate, timeout
  );
endinterface

// File: rtl/seq_delay_counter.sv
// Loadable down-counter; holds at zero.
// Used for stage delays and the gate watchdog.
module seq_delay_counter #(
  parameter int WIDTH = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  // load wins over decrement; stop at zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count <= '0;
    else if (load) count <= value;
    else if (en && count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/alpha_startup_sequencer.sv
// N-stage power-up sequencer with per-stage delay and gate.
// Watchdog on gate wait: ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN.
module alpha_startup_sequencer
  import alpha_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter logic [NUM_STAGES-1:0] GATED_MASK =
    NUM_STAGES'(DEF_GATED_MASK)
`ifdef ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN
  , parameter int WATCHDOG_CYCLES = DEF_WATCHDOG_CYCLES
`endif
) (
  input  logic clock,
  input  logic reset,
  alpha_startup_sequencer_if.slave bus
);
  localparam int IW = idx_width(NUM_STAGES);
  localparam logic [IW-1:0] LAST = IW'(NUM_STAGES - 1);

  seq_state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic cnt_load, cnt_en, cnt_zero, clr;
  logic [DELAY_WIDTH-1:0] cnt_val;
  logic [NUM_STAGES-1:0] pulse_nx;
  logic [NUM_STAGES-1:0] pulse_q, done_q;
  logic busy_q, all_done_q, waiting_q;

`ifdef ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic wd_load, wd_en, wd_zero, wd_trip, timeout_q;
`endif

  // Delay of the stage being entered, sampled only on load
  assign cnt_val =
    bus.stage_delay[idx_nx*DELAY_WIDTH +: DELAY_WIDTH];

  seq_delay_counter #(.WIDTH(DELAY_WIDTH)) u_dly (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .value (cnt_val),
    .zero  (cnt_zero)
  );

  // Next state; abort overrides everything else
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    clr      = 1'b0;
`ifdef ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN
    wd_trip  = 1'b0;
`endif
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          clr      = 1'b1;
          idx_nx   = '0;
          cnt_load = 1'b1;
          state_nx = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (cnt_zero)
          state_nx = GATED_MASK[idx] ? ST_WAIT_GATE : ST_FIRE;
        else
          cnt_en = 1'b1;
      end
      ST_WAIT_GATE: begin
        if (bus.gate) state_nx = ST_FIRE;
`ifdef ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN
        else if (wd_zero) begin
          state_nx = ST_IDLE;
          wd_trip  = 1'b1;
        end
`endif
      end
      ST_FIRE: begin
        if (idx == LAST) begin
          state_nx = ST_DONE;
        end else begin
          idx_nx   = idx + 1'b1;
          cnt_load = 1'b1;
          state_nx = ST_DELAY;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (bus.abort) begin
      state_nx = ST_IDLE;
      idx_nx   = idx;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      clr      = 1'b0;
`ifdef ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN
      wd_trip  = 1'b0;
`endif
    end
  end

  // Pulse lines up with the FIRE cycle of the current stage
  assign pulse_nx = (state_nx == ST_FIRE) ?
    (NUM_STAGES'(1) << idx_nx) : '0;

  // State, index and registered status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pulse_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      waiting_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      pulse_q    <= pulse_nx;
      done_q     <= clr ? '0 : (done_q | pulse_nx);
      busy_q     <= (state_nx == ST_DELAY) ||
                    (state_nx == ST_WAIT_GATE) ||
                    (state_nx == ST_FIRE);
      all_done_q <= (state_nx == ST_DONE);
      waiting_q  <= (state_nx == ST_WAIT_GATE);
    end
  end

`ifdef ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN
  assign wd_load = (state_nx == ST_WAIT_GATE) &&
                   (state != ST_WAIT_GATE);
  assign wd_en   = (state == ST_WAIT_GATE);

  seq_delay_counter #(.WIDTH(WD_W)) u_wd (
    .clock (clock),
    .reset (reset),
    .load  (wd_load),
    .en    (wd_en),
    .value (WD_W'(WATCHDOG_CYCLES - 1)),
    .zero  (wd_zero)
  );

  // Sticky timeout, cleared by the next start
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) timeout_q <= 1'b0;
    else if (clr) timeout_q <= 1'b0;
    else if (wd_trip) timeout_q <= 1'b1;
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.stage_pulse   = pulse_q;
  assign bus.stage_done    = done_q;
  assign bus.current_stage = idx;
  assign bus.busy          = busy_q;
  assign bus.all_done      = all_done_q;
  assign bus.waiting_gate  = waiting_q;
endmodule

// File: tb/tb_alpha_startup_sequencer.sv
// Scoreboard bench: gated (mask 1000) and ungated DUTs in lockstep.
// Watchdog case runs when ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN is set.
module tb_alpha_startup_sequencer;
  localparam int N  = 4;
  localparam int DW = 27;
  localparam int WD = 20;

  typedef struct {
    int c;
    int s;
  } exp_t;

  logic clock;
  logic reset;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int d[N];
  int pc[N];
  int fire_g;
  exp_t qg[$];
  exp_t qu[$];
  exp_t eg, eu;

  alpha_startup_sequencer_if #(.NUM_STAGES(N), .DELAY_WIDTH(DW)) bg ();
  alpha_startup_sequencer_if #(.NUM_STAGES(N), .DELAY_WIDTH(DW)) bu ();

  alpha_startup_sequencer #(
    .NUM_STAGES(N), .DELAY_WIDTH(DW), .GATED_MASK(4'b1000)
`ifdef ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN
    , .WATCHDOG_CYCLES(WD)
`endif
  ) u_gated (.clock(clock), .reset(reset), .bus(bg));

  alpha_startup_sequencer #(
    .NUM_STAGES(N), .DELAY_WIDTH(DW), .GATED_MASK(4'b0000)
`ifdef ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN
    , .WATCHDOG_CYCLES(WD)
`endif
  ) u_free (.clock(clock), .reset(reset), .bus(bu));

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    bg.stage_delay = '0;
    for (int i = 0; i < N; i++)
      bg.stage_delay[i*DW +: DW] = d[i][DW-1:0];
  end

  assign bu.start       = bg.start;
  assign bu.abort       = bg.abort;
  assign bu.gate        = bg.gate;
  assign bu.stage_delay = bg.stage_delay;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  task automatic push_g(input int c, input int s);
    exp_t t;
    t.c = c;
    t.s = s;
    qg.push_back(t);
  endtask

  task automatic push_u(input int c, input int s);
    exp_t t;
    t.c = c;
    t.s = s;
    qu.push_back(t);
  endtask

  // Pulse cycles for a run whose first DELAY cycle is e0;
  // gated DUT enters WAIT_GATE in cycle pc[3]
  task automatic plan(input int e0, input int upto);
    int e;
    e = e0;
    for (int s = 0; s < N; s++) begin
      pc[s] = e + d[s] + 1;
      if (s < upto) begin
        if (s < 3) push_g(pc[s], s);
        push_u(pc[s], s);
      end
      e = pc[s] + 1;
    end
  endtask

  task automatic kick(input int upto);
    @(negedge clock);
    plan(cyc + 1, upto);
    bg.start = 1'b1;
    @(negedge clock);
    bg.start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  function automatic int exp_idx(input int c);
    if (c <= pc[0]) return 0;
    if (c <= pc[1]) return 1;
    if (c <= pc[2]) return 2;
    return 3;
  endfunction

  always @(negedge clock) begin
    if (bg.stage_pulse != '0) begin
      if (qg.size() == 0) begin
        check("g_unexp_pulse", 32'(bg.stage_pulse), 0);
      end else begin
        eg = qg.pop_front();
        check("g_pulse_cyc", cyc, eg.c);
        check("g_pulse_idx", 32'(bg.stage_pulse), 1 << eg.s);
        check("g_done_bit", 32'(bg.stage_done[eg.s]), 1);
      end
    end
    if (bu.stage_pulse != '0) begin
      if (qu.size() == 0) begin
        check("u_unexp_pulse", 32'(bu.stage_pulse), 0);
      end else begin
        eu = qu.pop_front();
        check("u_pulse_cyc", cyc, eu.c);
        check("u_pulse_idx", 32'(bu.stage_pulse), 1 << eu.s);
        check("u_done_bit", 32'(bu.stage_done[eu.s]), 1);
      end
    end
  end

  initial begin
    reset = 1'b0;
    bg.start = 1'b0;
    bg.abort = 1'b0;
    bg.gate = 1'b0;
    d[0] = 2;
    d[1] = 0;
    d[2] = 3;
    d[3] = 5;
    repeat (3) @(negedge clock);
    check("rst_pulse", 32'(bg.stage_pulse), 0);
    check("rst_done", 32'(bg.stage_done), 0);
    check("rst_busy", 32'(bg.busy), 0);
    check("rst_stage", 32'(bg.current_stage), 0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_busy", 32'(bg.busy), 0);
    check("idle_all_done", 32'(bg.all_done), 0);
    check("idle_wait", 32'(bg.waiting_gate), 0);
    check("idle_timeout", 32'(bg.timeout), 0);

    // full run; stray gate in stage 1 DELAY, real gate later
    kick(4);
    fire_g = pc[3] + 10;
    while (cyc <= fire_g + 2) begin
      bg.gate = (cyc == pc[0] + 1) || (cyc == fire_g - 1);
      if (cyc == fire_g - 1) push_g(fire_g, 3);
      check("g_busy", 32'(bg.busy), 32'(cyc <= fire_g));
      check("g_all_done", 32'(bg.all_done), 32'(cyc > fire_g));
      check("g_wait", 32'(bg.waiting_gate),
            32'(cyc >= pc[3] && cyc < fire_g));
      check("g_stage", 32'(bg.current_stage), exp_idx(cyc));
      check("u_busy", 32'(bu.busy), 32'(cyc <= pc[3]));
      check("u_all_done", 32'(bu.all_done), 32'(cyc > pc[3]));
      @(negedge clock);
    end
    bg.gate = 1'b0;

    // abort in stage 2 DELAY, after a restart from DONE
    kick(2);
    check("g_done_clr", 32'(bg.stage_done), 0);
    check("u_done_clr", 32'(bu.stage_done), 0);
    wait_cyc(pc[1] + 2);
    bg.abort = 1'b1;
    @(negedge clock);
    bg.abort = 1'b0;
    check("ab_busy", 32'(bg.busy), 0);
    check("ab_all_done", 32'(bu.all_done), 0);
    check("ab_g_done", 32'(bg.stage_done), 32'h3);
    check("ab_u_done", 32'(bu.stage_done), 32'h3);
    wait_cyc(pc[2] + 3);
    check("ab_idle", 32'(bu.busy), 0);

    // start while busy ignored; delay change mid-DELAY ignored
    kick(4);
    bg.start = 1'b1;
    d[0] = 9;
    @(negedge clock);
    bg.start = 1'b0;
    wait_cyc(pc[3] + 3);
    check("t4_g_wait", 32'(bg.waiting_gate), 1);
    check("t4_u_all_done", 32'(bu.all_done), 1);
    bg.abort = 1'b1;
    bg.start = 1'b1;
    @(negedge clock);
    bg.abort = 1'b0;
    bg.start = 1'b0;
    check("sa_g_busy", 32'(bg.busy), 0);
    check("sa_g_wait", 32'(bg.waiting_gate), 0);
    check("sa_u_all_done", 32'(bu.all_done), 0);
    check("sa_u_busy", 32'(bu.busy), 0);
    check("sa_g_done", 32'(bg.stage_done), 32'h7);
    check("sa_u_done", 32'(bu.stage_done), 32'hf);
    d[0] = 2;
    repeat (3) @(negedge clock);

    // reset asserted inside the first FIRE cycle
    kick(0);
    wait_cyc(pc[0] - 1);
    @(posedge clock);
    #1;
    check("fire_seen", 32'(bg.stage_pulse), 32'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_pulse_g", 32'(bg.stage_pulse), 0);
    check("mid_rst_pulse_u", 32'(bu.stage_pulse), 0);
    check("mid_rst_done", 32'(bg.stage_done), 0);
    check("mid_rst_busy", 32'(bg.busy), 0);
    check("mid_rst_stage", 32'(bu.current_stage), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("post_rst_busy", 32'(bu.busy), 0);
    check("post_rst_done", 32'(bu.stage_done), 0);

`ifdef ALPHA_STARTUP_SEQUENCER_WATCHDOG_EN
    kick(4);
    wait_cyc(pc[3] + WD - 1);
    check("wd_wait", 32'(bg.waiting_gate), 1);
    check("wd_pre", 32'(bg.timeout), 0);
    @(negedge clock);
    check("wd_timeout", 32'(bg.timeout), 1);
    check("wd_idle", 32'(bg.busy), 0);
    check("wd_nowait", 32'(bg.waiting_gate), 0);
    check("wd_done", 32'(bg.stage_done), 32'h7);
    kick(4);
    check("wd_clr", 32'(bg.timeout), 0);
    wait_cyc(pc[3] + WD - 1);
    bg.gate = 1'b1;
    push_g(pc[3] + WD, 3);
    @(negedge clock);
    bg.gate = 1'b0;
    check("wd_race_to", 32'(bg.timeout), 0);
    @(negedge clock);
    check("wd_race_done", 32'(bg.all_done), 1);
    check("wd_race_to2", 32'(bg.timeout), 0);
`endif

    repeat (4) @(negedge clock);
    check("g_queue_empty", qg.size(), 0);
    check("u_queue_empty", qu.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
